// File: rtl/hpdcache_wbuf_mem_bridge_pkg.sv
// Shared types and elaboration-time helpers for the wbuf-to-memory write bridge:
// burst shape (len/size) and the width ratio between the two data paths.
package hpdcache_pkg;

  localparam int unsigned MemLenWidth  = 8;
  localparam int unsigned MemSizeWidth = 3;

  typedef enum logic {
    BRIDGE_UPSIZE,
    BRIDGE_DOWNSIZE
  } bridge_mode_e;

  function automatic bridge_mode_e bridge_mode(input int unsigned wbuf_bits, input int unsigned mem_bits);
    return (mem_bits >= wbuf_bits) ? BRIDGE_UPSIZE : BRIDGE_DOWNSIZE;
  endfunction

  function automatic logic [MemSizeWidth-1:0] mem_size_enc(input int unsigned beat_bits);
    return MemSizeWidth'($clog2(beat_bits / 8));
  endfunction

  function automatic int unsigned beat_ratio(input int unsigned wide_bits, input int unsigned narrow_bits);
    return wide_bits / narrow_bits;
  endfunction

  // Upsizing always sends a single beat, downsizing splits one buffer into wbuf/mem beats.
  function automatic logic [MemLenWidth-1:0] burst_len(input int unsigned wbuf_bits, input int unsigned mem_bits);
    return (mem_bits >= wbuf_bits) ? '0 : MemLenWidth'(wbuf_bits / mem_bits - 1);
  endfunction

endpackage

// File: rtl/hpdcache_wbuf_mem_bridge_if.sv
// Bundle of the wbuf send/ack channels, the memory write channels and bridge status.
// The slave modport is the bridge's view; master is the surrounding wbuf + memory.
interface hpdcache_wbuf_mem_bridge_if #(
  parameter int unsigned WbufDataWidth = 128,
  parameter int unsigned MemDataWidth  = 64,
  parameter int unsigned AddrWidth     = 49,
  parameter int unsigned WbufIdWidth   = 3,
  parameter int unsigned MemIdWidth    = 8
);

  logic                       send_meta_valid;
  logic                       send_meta_ready;
  logic [AddrWidth-1:0]       send_addr;
  logic [WbufIdWidth-1:0]     send_id;
  logic                       send_uc;
  logic                       send_data_valid;
  logic                       send_data_ready;
  logic [AddrWidth-1:0]       send_data_tag;
  logic [WbufDataWidth-1:0]   send_data;
  logic [WbufDataWidth/8-1:0] send_be;
  logic                       ack;
  logic [WbufIdWidth-1:0]     ack_id;
  logic                       ack_error;

  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [AddrWidth-1:0]       mem_req_addr;
  logic [7:0]                 mem_req_len;
  logic [2:0]                 mem_req_size;
  logic [MemIdWidth-1:0]      mem_req_id;
  logic                       mem_req_cacheable;
  logic                       mem_w_valid;
  logic                       mem_w_ready;
  logic [MemDataWidth-1:0]    mem_w_data;
  logic [MemDataWidth/8-1:0]  mem_w_be;
  logic                       mem_w_last;
  logic                       mem_resp_valid;
  logic [MemIdWidth-1:0]      mem_resp_id;
  logic                       mem_resp_error;

  logic [WbufIdWidth:0]       outstanding;
  logic                       idle;
  logic                       spurious;

  modport slave (
    input  send_meta_valid, send_addr, send_id, send_uc,
    input  send_data_valid, send_data_tag, send_data, send_be,
    input  mem_req_ready, mem_w_ready, mem_resp_valid, mem_resp_id, mem_resp_error,
    output send_meta_ready, send_data_ready, ack, ack_id, ack_error,
    output mem_req_valid, mem_req_addr, mem_req_len, mem_req_size, mem_req_id, mem_req_cacheable,
    output mem_w_valid, mem_w_data, mem_w_be, mem_w_last,
    output outstanding, idle, spurious
  );

  modport master (
    output send_meta_valid, send_addr, send_id, send_uc,
    output send_data_valid, send_data_tag, send_data, send_be,
    output mem_req_ready, mem_w_ready, mem_resp_valid, mem_resp_id, mem_resp_error,
    input  send_meta_ready, send_data_ready, ack, ack_id, ack_error,
    input  mem_req_valid, mem_req_addr, mem_req_len, mem_req_size, mem_req_id, mem_req_cacheable,
    input  mem_w_valid, mem_w_data, mem_w_be, mem_w_last,
    input  outstanding, idle, spurious
  );

endinterface

// File: rtl/hpdcache_wbuf_mem_beat_slicer.sv
// Downsizing data path: walks one wbuf buffer out as wbuf/mem narrow beats,
// selecting the data and byte-enable slice for the current beat.
module hpdcache_wbuf_mem_beat_slicer
  import hpdcache_pkg::*;
#(
  parameter int unsigned WbufDataWidth = 128,
  parameter int unsigned MemDataWidth  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_valid,
  input  logic [WbufDataWidth-1:0]   data,
  input  logic [WbufDataWidth/8-1:0] be,
  input  logic                       w_ready,
  output logic                       w_valid,
  output logic [MemDataWidth-1:0]    w_data,
  output logic [MemDataWidth/8-1:0]  w_be,
  output logic                       w_last,
  output logic                       data_ready,
  output logic                       beat_idle
);

  localparam int unsigned MemBeWidth = MemDataWidth / 8;
  localparam int unsigned Ratio      = beat_ratio(WbufDataWidth, MemDataWidth);
  localparam int unsigned CntWidth   = $clog2(Ratio);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Ratio - 1);

  logic [CntWidth-1:0] beat_q;
  logic                fire;

  // The wbuf holds the buffer stable until data_ready, so slices are muxed straight from it.
  assign w_valid    = ~rst & data_valid;
  assign fire       = w_valid & w_ready;
  assign w_last     = (beat_q == LastBeat);
  assign w_data     = data[beat_q*MemDataWidth +: MemDataWidth];
  assign w_be       = be[beat_q*MemBeWidth +: MemBeWidth];
  assign data_ready = ~rst & w_ready & w_last;
  assign beat_idle  = (beat_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else if (fire) begin
      beat_q <= w_last ? '0 : beat_q + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_wbuf_mem_bridge.sv
// Write-buffer to memory write-channel bridge: per-ID outstanding tracking,
// issue throttling, width adaptation (up/downsizing) and spurious response detection.
module hpdcache_wbuf_mem_bridge
  import hpdcache_pkg::*;
#(
  parameter int unsigned WbufDataWidth = 128,
  parameter int unsigned MemDataWidth  = 64,
  parameter int unsigned AddrWidth     = 49,
  parameter int unsigned WbufIdWidth   = 3,
  parameter int unsigned MemIdWidth    = 8
) (
  input logic                          clk_i,
  input logic                          rst_i,
  hpdcache_wbuf_mem_bridge_if.slave    bus
);

  localparam int unsigned MaxOutstanding = 2 ** WbufIdWidth;
  localparam int unsigned CntWidth       = WbufIdWidth + 1;
  localparam int unsigned WbufBeWidth    = WbufDataWidth / 8;
  localparam int unsigned MemBeWidth     = MemDataWidth / 8;
  localparam int unsigned BeatBits       = (MemDataWidth >= WbufDataWidth) ? WbufDataWidth : MemDataWidth;
  localparam bridge_mode_e Mode          = bridge_mode(WbufDataWidth, MemDataWidth);
  localparam logic [MemLenWidth-1:0]  ReqLen  = burst_len(WbufDataWidth, MemDataWidth);
  localparam logic [MemSizeWidth-1:0] ReqSize = mem_size_enc(BeatBits);

  if (MemIdWidth < WbufIdWidth) begin : g_bad_id_width
    $error("hpdcache_wbuf_mem_bridge: MemIdWidth must be >= WbufIdWidth");
  end

  logic [MaxOutstanding-1:0] pend_q, pend_d, set_mask, clr_mask;
  logic [CntWidth-1:0]       outstanding_q, outstanding_d;
  logic                      spurious_q;
  logic                      full, meta_ok, req_fire, resp_hit, beat_idle;
  logic [WbufIdWidth-1:0]    resp_wbuf_id;

  // An ID may only be reissued once its previous write has been acknowledged.
  assign full    = (outstanding_q == CntWidth'(MaxOutstanding));
  assign meta_ok = ~rst_i & ~full & ~pend_q[bus.send_id];

  assign bus.mem_req_valid     = bus.send_meta_valid & meta_ok;
  assign bus.send_meta_ready   = bus.mem_req_ready & meta_ok;
  assign req_fire              = bus.mem_req_valid & bus.mem_req_ready;
  assign bus.mem_req_addr      = bus.send_addr;
  assign bus.mem_req_len       = ReqLen;
  assign bus.mem_req_size      = ReqSize;
  assign bus.mem_req_id        = MemIdWidth'(bus.send_id);
  assign bus.mem_req_cacheable = ~bus.send_uc;

  // IDs carrying non-zero upper bits can never belong to a request we issued.
  assign resp_wbuf_id  = bus.mem_resp_id[WbufIdWidth-1:0];
  assign resp_hit      = ~rst_i & bus.mem_resp_valid
                       & (bus.mem_resp_id == MemIdWidth'(resp_wbuf_id))
                       & pend_q[resp_wbuf_id];
  assign bus.ack       = resp_hit;
  assign bus.ack_id    = resp_wbuf_id;
  assign bus.ack_error = bus.mem_resp_error;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (req_fire) set_mask[bus.send_id] = 1'b1;
    if (resp_hit) clr_mask[resp_wbuf_id] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    outstanding_d = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      outstanding_d = outstanding_d + CntWidth'(pend_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q        <= '0;
      outstanding_q <= '0;
      spurious_q    <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      outstanding_q <= outstanding_d;
      if (bus.mem_resp_valid && !resp_hit) spurious_q <= 1'b1;
    end
  end

  assign bus.outstanding = outstanding_q;
  assign bus.idle        = (pend_q == '0) & beat_idle;
  assign bus.spurious    = spurious_q;

  if (Mode == BRIDGE_UPSIZE) begin : g_upsize
    localparam int unsigned Ratio     = MemDataWidth / WbufDataWidth;
    localparam int unsigned OffsetLsb = $clog2(WbufBeWidth);
    logic [MemBeWidth-1:0] be_placed;

    if (Ratio == 1) begin : g_same_width
      assign be_placed = bus.send_be;
    end else begin : g_wide
      localparam int unsigned SelWidth = $clog2(Ratio);
      logic [SelWidth-1:0] sel;
      // The address tag picks which wbuf-sized lane of the wide beat is written.
      assign sel       = bus.send_data_tag[OffsetLsb +: SelWidth];
      assign be_placed = MemBeWidth'(bus.send_be) << (sel * WbufBeWidth);
    end

    assign bus.mem_w_valid     = ~rst_i & bus.send_data_valid;
    assign bus.mem_w_data      = {Ratio{bus.send_data}};
    assign bus.mem_w_be        = be_placed;
    assign bus.mem_w_last      = 1'b1;
    assign bus.send_data_ready = ~rst_i & bus.mem_w_ready;
    assign beat_idle           = 1'b1;
  end else begin : g_downsize
    hpdcache_wbuf_mem_beat_slicer #(
      .WbufDataWidth (WbufDataWidth),
      .MemDataWidth  (MemDataWidth)
    ) u_slicer (
      .clk        (clk_i),
      .rst        (rst_i),
      .data_valid (bus.send_data_valid),
      .data       (bus.send_data),
      .be         (bus.send_be),
      .w_ready    (bus.mem_w_ready),
      .w_valid    (bus.mem_w_valid),
      .w_data     (bus.mem_w_data),
      .w_be       (bus.mem_w_be),
      .w_last     (bus.mem_w_last),
      .data_ready (bus.send_data_ready),
      .beat_idle  (beat_idle)
    );
  end

endmodule

// File: tb/tb_hpdcache_wbuf_mem_bridge.sv
// Directed bench: an upsizing instance (128->512) driven from a vector table and a
// downsizing instance (128->32) exercised with hand-written multi-cycle sequences.
module tb_hpdcache_wbuf_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hpdcache_wbuf_mem_bridge_if #(.WbufDataWidth(128), .MemDataWidth(512), .AddrWidth(49),
                                .WbufIdWidth(3), .MemIdWidth(8)) up_bus ();
  hpdcache_wbuf_mem_bridge_if #(.WbufDataWidth(128), .MemDataWidth(32), .AddrWidth(49),
                                .WbufIdWidth(3), .MemIdWidth(8)) dn_bus ();

  hpdcache_wbuf_mem_bridge #(.WbufDataWidth(128), .MemDataWidth(512), .AddrWidth(49),
                             .WbufIdWidth(3), .MemIdWidth(8)) dut_up (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (up_bus)
  );

  hpdcache_wbuf_mem_bridge #(.WbufDataWidth(128), .MemDataWidth(32), .AddrWidth(49),
                             .WbufIdWidth(3), .MemIdWidth(8)) dut_dn (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dn_bus)
  );

  typedef struct {
    logic [48:0]  tag;
    logic [15:0]  be;
    logic         data_valid;
    logic         w_ready;
    logic [63:0]  exp_be;
    logic         exp_w_valid;
    logic         exp_data_ready;
  } up_vec_t;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input up_vec_t v, input logic [127:0] data);
    up_bus.send_data_tag   = v.tag;
    up_bus.send_be         = v.be;
    up_bus.send_data_valid = v.data_valid;
    up_bus.mem_w_ready     = v.w_ready;
    up_bus.send_data       = data;
  endtask

  task automatic clear_dn_inputs();
    dn_bus.send_meta_valid = 1'b0;
    dn_bus.send_data_valid = 1'b0;
    dn_bus.mem_req_ready   = 1'b0;
    dn_bus.mem_w_ready     = 1'b0;
    dn_bus.mem_resp_valid  = 1'b0;
    dn_bus.mem_resp_error  = 1'b0;
  endtask

  initial begin
    up_vec_t       vecs [5];
    logic [127:0]  up_data;
    logic [31:0]   exp_word [4];
    logic [3:0]    exp_be [4];
    int            k_exp;
    int            ready_pulses;

    up_bus.send_meta_valid = 1'b0; up_bus.send_addr = '0; up_bus.send_id = '0; up_bus.send_uc = 1'b0;
    up_bus.send_data_valid = 1'b0; up_bus.send_data_tag = '0; up_bus.send_data = '0; up_bus.send_be = '0;
    up_bus.mem_req_ready = 1'b0; up_bus.mem_w_ready = 1'b0; up_bus.mem_resp_valid = 1'b0;
    up_bus.mem_resp_id = '0; up_bus.mem_resp_error = 1'b0;
    dn_bus.send_addr = '0; dn_bus.send_id = '0; dn_bus.send_uc = 1'b0; dn_bus.send_data_tag = '0;
    dn_bus.send_data = '0; dn_bus.send_be = '0; dn_bus.mem_resp_id = '0;
    clear_dn_inputs();

    vecs[0] = '{49'h30,   16'hFFFF, 1'b1, 1'b1, 64'hFFFF_0000_0000_0000, 1'b1, 1'b1};
    vecs[1] = '{49'h00,   16'h00FF, 1'b1, 1'b0, 64'h0000_0000_0000_00FF, 1'b1, 1'b0};
    vecs[2] = '{49'h10,   16'h1234, 1'b0, 1'b1, 64'h0000_0000_1234_0000, 1'b0, 1'b1};
    vecs[3] = '{49'h25,   16'hA5A5, 1'b1, 1'b1, 64'h0000_A5A5_0000_0000, 1'b1, 1'b1};
    vecs[4] = '{49'h7F30, 16'h8001, 1'b1, 1'b0, 64'h8001_0000_0000_0000, 1'b1, 1'b0};
    up_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    exp_word = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    exp_be   = '{4'h3, 4'hC, 4'h0, 4'hF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_outstanding", dn_bus.outstanding, 4'd0);
    checkOutput("reset_idle", dn_bus.idle, 1'b1);
    checkOutput("reset_spurious", dn_bus.spurious, 1'b0);
    checkOutput("reset_req_valid", dn_bus.mem_req_valid, 1'b0);
    checkOutput("reset_w_valid", dn_bus.mem_w_valid, 1'b0);
    checkOutput("reset_ack", dn_bus.ack, 1'b0);
    checkOutput("reset_up_idle", up_bus.idle, 1'b1);

    // Upsizing: byte-enable lane placement and replication.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i], up_data);
      #1;
      checkOutput($sformatf("up_be[%0d]", i), up_bus.mem_w_be, vecs[i].exp_be);
      checkOutput($sformatf("up_w_valid[%0d]", i), up_bus.mem_w_valid, vecs[i].exp_w_valid);
      checkOutput($sformatf("up_data_ready[%0d]", i), up_bus.send_data_ready, vecs[i].exp_data_ready);
      checkOutput($sformatf("up_data[%0d]", i), up_bus.mem_w_data, {4{up_data}});
      checkOutput($sformatf("up_last[%0d]", i), up_bus.mem_w_last, 1'b1);
    end
    checkOutput("up_len", up_bus.mem_req_len, 8'd0);
    checkOutput("up_size", up_bus.mem_req_size, 3'd4);
    up_bus.send_data_valid = 1'b0;

    // Downsizing: one buffer as four beats with a toggling ready.
    checkOutput("dn_len", dn_bus.mem_req_len, 8'd3);
    checkOutput("dn_size", dn_bus.mem_req_size, 3'd2);
    k_exp = 0;
    ready_pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dn_bus.send_data_valid = 1'b1;
      dn_bus.send_data       = {exp_word[3], exp_word[2], exp_word[1], exp_word[0]};
      dn_bus.send_be         = 16'hF0C3;
      dn_bus.mem_w_ready     = (c % 2 == 1);
      #1;
      checkOutput($sformatf("dn_w_valid[%0d]", c), dn_bus.mem_w_valid, 1'b1);
      checkOutput($sformatf("dn_w_data[%0d]", c), dn_bus.mem_w_data, exp_word[k_exp]);
      checkOutput($sformatf("dn_w_be[%0d]", c), dn_bus.mem_w_be, exp_be[k_exp]);
      checkOutput($sformatf("dn_w_last[%0d]", c), dn_bus.mem_w_last, (k_exp == 3));
      checkOutput($sformatf("dn_data_ready[%0d]", c), dn_bus.send_data_ready, (c % 2 == 1) && (k_exp == 3));
      if (c == 2) checkOutput("dn_idle_mid_burst", dn_bus.idle, 1'b0);
      if (dn_bus.send_data_ready) ready_pulses++;
      if (c % 2 == 1) k_exp = (k_exp + 1) % 4;
    end
    @(negedge clk);
    clear_dn_inputs();
    #1;
    checkOutput("dn_ready_pulses", ready_pulses, 1);
    checkOutput("dn_idle_after_burst", dn_bus.idle, 1'b1);

    // Fill every ID, then check the throttle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dn_bus.send_meta_valid = 1'b1;
      dn_bus.mem_req_ready   = 1'b1;
      dn_bus.send_id         = 3'(i);
      dn_bus.send_addr       = 49'h1000 + 49'(i * 64);
      dn_bus.send_uc         = (i % 2 == 1);
      #1;
      checkOutput($sformatf("issue_valid[%0d]", i), dn_bus.mem_req_valid, 1'b1);
      checkOutput($sformatf("issue_ready[%0d]", i), dn_bus.send_meta_ready, 1'b1);
      checkOutput($sformatf("issue_id[%0d]", i), dn_bus.mem_req_id, 8'(i));
      checkOutput($sformatf("issue_addr[%0d]", i), dn_bus.mem_req_addr, 49'h1000 + 49'(i * 64));
      checkOutput($sformatf("issue_cacheable[%0d]", i), dn_bus.mem_req_cacheable, (i % 2 == 0));
    end
    @(negedge clk);
    dn_bus.send_id = 3'd0;
    #1;
    checkOutput("full_outstanding", dn_bus.outstanding, 4'd8);
    checkOutput("full_req_valid", dn_bus.mem_req_valid, 1'b0);
    checkOutput("full_meta_ready", dn_bus.send_meta_ready, 1'b0);
    checkOutput("full_idle", dn_bus.idle, 1'b0);

    @(negedge clk);
    clear_dn_inputs();
    dn_bus.mem_resp_valid = 1'b1;
    dn_bus.mem_resp_id    = 8'd5;
    #1;
    checkOutput("resp5_ack", dn_bus.ack, 1'b1);
    checkOutput("resp5_ack_id", dn_bus.ack_id, 3'd5);
    checkOutput("resp5_ack_error", dn_bus.ack_error, 1'b0);
    @(negedge clk);
    clear_dn_inputs();
    dn_bus.send_meta_valid = 1'b1;
    dn_bus.send_id         = 3'd5;
    #1;
    checkOutput("resp5_outstanding", dn_bus.outstanding, 4'd7);
    checkOutput("reissue5_req_valid", dn_bus.mem_req_valid, 1'b1);
    checkOutput("reissue5_meta_ready", dn_bus.send_meta_ready, 1'b0);

    // Erroneous response, then a duplicate that must be flagged as spurious.
    @(negedge clk);
    clear_dn_inputs();
    dn_bus.mem_resp_valid = 1'b1;
    dn_bus.mem_resp_id    = 8'd2;
    dn_bus.mem_resp_error = 1'b1;
    #1;
    checkOutput("resp2_ack", dn_bus.ack, 1'b1);
    checkOutput("resp2_ack_error", dn_bus.ack_error, 1'b1);
    @(negedge clk);
    dn_bus.mem_resp_error = 1'b0;
    #1;
    checkOutput("resp2_dup_ack", dn_bus.ack, 1'b0);
    checkOutput("resp2_dup_spurious_not_yet", dn_bus.spurious, 1'b0);
    @(negedge clk);
    clear_dn_inputs();
    #1;
    checkOutput("spurious_set", dn_bus.spurious, 1'b1);
    checkOutput("resp2_outstanding", dn_bus.outstanding, 4'd6);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("spurious_sticky", dn_bus.spurious, 1'b1);

    // Free ID 3, then issue ID 3 while ID 1 is acknowledged in the same cycle.
    @(negedge clk);
    dn_bus.mem_resp_valid = 1'b1;
    dn_bus.mem_resp_id    = 8'd3;
    #1;
    checkOutput("resp3_ack", dn_bus.ack, 1'b1);
    @(negedge clk);
    dn_bus.mem_resp_id     = 8'd1;
    dn_bus.send_meta_valid = 1'b1;
    dn_bus.mem_req_ready   = 1'b1;
    dn_bus.send_id         = 3'd3;
    #1;
    checkOutput("same_cycle_req_valid", dn_bus.mem_req_valid, 1'b1);
    checkOutput("same_cycle_ack", dn_bus.ack, 1'b1);
    checkOutput("same_cycle_ack_id", dn_bus.ack_id, 3'd1);
    @(negedge clk);
    clear_dn_inputs();
    #1;
    checkOutput("same_cycle_outstanding", dn_bus.outstanding, 4'd5);
    dn_bus.send_meta_valid = 1'b1;
    dn_bus.send_id         = 3'd3;
    #1;
    checkOutput("pend3_blocks", dn_bus.mem_req_valid, 1'b0);
    dn_bus.send_id = 3'd1;
    #1;
    checkOutput("pend1_free", dn_bus.mem_req_valid, 1'b1);

    // Upper ID bits set: never matches, even though the low bits are outstanding.
    @(negedge clk);
    clear_dn_inputs();
    dn_bus.mem_resp_valid = 1'b1;
    dn_bus.mem_resp_id    = 8'h0C;
    #1;
    checkOutput("wide_id_no_ack", dn_bus.ack, 1'b0);

    // Reset in the middle of a burst, then a stale response.
    @(negedge clk);
    clear_dn_inputs();
    dn_bus.send_data_valid = 1'b1;
    dn_bus.mem_w_ready     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid_burst_slice2", dn_bus.mem_w_data, exp_word[2]);
    rst = 1'b1;
    dn_bus.send_meta_valid = 1'b1;
    dn_bus.send_id         = 3'd2;
    #1;
    checkOutput("rst_w_valid", dn_bus.mem_w_valid, 1'b0);
    checkOutput("rst_data_ready", dn_bus.send_data_ready, 1'b0);
    checkOutput("rst_req_valid", dn_bus.mem_req_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_dn_inputs();
    #1;
    checkOutput("post_rst_idle", dn_bus.idle, 1'b1);
    checkOutput("post_rst_outstanding", dn_bus.outstanding, 4'd0);
    checkOutput("post_rst_spurious", dn_bus.spurious, 1'b0);
    checkOutput("post_rst_last", dn_bus.mem_w_last, 1'b0);
    dn_bus.mem_resp_valid = 1'b1;
    dn_bus.mem_resp_id    = 8'd4;
    #1;
    checkOutput("stale_resp_ack", dn_bus.ack, 1'b0);
    @(negedge clk);
    clear_dn_inputs();
    #1;
    checkOutput("stale_resp_spurious", dn_bus.spurious, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
